// File: rtl/multi_channel_error_accumulator_pkg.sv
// rtl/multi_channel_error_accumulator_pkg.sv - shared modes and saturation limits
package multi_channel_error_accumulator_pkg;

  localparam logic MODE_DC  = 1'b0;
  localparam logic MODE_ABS = 1'b1;

  // Largest value representable in a w-bit two's complement word
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/multi_channel_error_accumulator_channel.sv
// rtl/multi_channel_error_accumulator_channel.sv - one channel: term select, saturating add, sticky ovf, mean
module error_acc_channel
  import multi_channel_error_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH     = 18,
  parameter int ACC_DATA_WIDTH = 36,
  parameter int LEN_W          = 5
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             ena,
  input  logic                             dump,
  input  logic                             mode_l,
  input  logic [LEN_W-1:0]                 len_l,
  input  logic signed [DATA_WIDTH-1:0]     error,
  output logic signed [ACC_DATA_WIDTH-1:0] acc_out,
  output logic signed [DATA_WIDTH-1:0]     mean_out,
  output logic                             ovf_out
);

  localparam int AW = ACC_DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic signed [AW-1:0] ACC_MAX  = AW'(sat_max(AW));
  localparam logic signed [AW-1:0] ACC_MIN  = AW'(sat_min(AW));
  localparam logic signed [AW-1:0] DW_MAX_X = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] DW_MIN_X = AW'(sat_min(DW));
  localparam logic signed [DW-1:0] DW_MAX   = DW'(sat_max(DW));
  localparam logic signed [DW-1:0] DW_MIN   = DW'(sat_min(DW));

  logic signed [AW-1:0] acc;
  logic                 ovf_sticky;
  logic signed [DW:0]   err_x;
  logic signed [DW:0]   err_abs;
  logic signed [AW-1:0] term;
  logic signed [AW:0]   sum_x;
  logic                 add_ovf;
  logic signed [AW-1:0] sat_sum;
  logic signed [AW-1:0] shifted;
  logic signed [DW-1:0] mean_sat;

  // Term select, one-guard-bit add with clamp, and floor mean clamped to the sample width
  always_comb begin
    err_x    = {error[DW-1], error};
    err_abs  = err_x[DW] ? -err_x : err_x;
    term     = (mode_l == MODE_ABS) ? AW'($unsigned(err_abs)) : AW'(error);
    sum_x    = {acc[AW-1], acc} + {term[AW-1], term};
    add_ovf  = sum_x[AW] ^ sum_x[AW-1];
    sat_sum  = add_ovf ? (sum_x[AW] ? ACC_MIN : ACC_MAX) : sum_x[AW-1:0];
    shifted  = sat_sum >>> len_l;
    mean_sat = shifted[DW-1:0];
    if (shifted > DW_MAX_X) mean_sat = DW_MAX;
    else if (shifted < DW_MIN_X) mean_sat = DW_MIN;
  end

  // Accumulator and sticky overflow; dump registers the completed window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      acc_out    <= '0;
      mean_out   <= '0;
      ovf_out    <= 1'b0;
    end else if (clear) begin
      acc        <= ena ? term : '0;
      ovf_sticky <= 1'b0;
    end else if (dump) begin
      acc_out    <= sat_sum;
      mean_out   <= mean_sat;
      ovf_out    <= ovf_sticky | add_ovf;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (ena) begin
      acc        <= sat_sum;
      ovf_sticky <= ovf_sticky | add_ovf;
    end
  end

endmodule

// File: rtl/multi_channel_error_accumulator.sv
// rtl/multi_channel_error_accumulator.sv - windowed per-channel error accumulator with auto dump
module multi_channel_error_accumulator
  import multi_channel_error_accumulator_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DATA_WIDTH     = 18,
  parameter int ACC_DATA_WIDTH = 36,
  parameter int MAX_LOG2_LEN   = 16,
  parameter int LEN_W          = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sym_clk_ena,
  input  logic                               clear_accumulator,
  input  logic                               mode,
  input  logic [LEN_W-1:0]                   log2_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       error,
  output logic [NUM_CH*ACC_DATA_WIDTH-1:0]   acc_error_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]       mean_out,
  output logic [NUM_CH-1:0]                  ovf_out,
  output logic                               out_valid,
  output logic [MAX_LOG2_LEN:0]              sym_count
);

  localparam int CNT_W = MAX_LOG2_LEN + 1;

  logic [LEN_W-1:0] len_l;
  logic             mode_l;
  logic             started;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] len_eff;
  logic             mode_eff;
  logic [CNT_W-1:0] last_cnt;
  logic             dump;

  // Until the first edge after reset the window parameters come straight from the inputs
  always_comb begin
    len_in   = (log2_len > LEN_W'(MAX_LOG2_LEN)) ? LEN_W'(MAX_LOG2_LEN) : log2_len;
    len_eff  = started ? len_l : len_in;
    mode_eff = started ? mode_l : mode;
    last_cnt = (CNT_W'(1) << len_eff) - CNT_W'(1);
    // >= so a window restarted by clear-with-sample into length 1 still closes on the next sample
    dump     = sym_clk_ena & ~clear_accumulator & (sym_count >= last_cnt);
  end

  // Shared symbol counter, window parameter latches and dump strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_count <= '0;
      len_l     <= '0;
      mode_l    <= MODE_DC;
      started   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dump;
      started   <= 1'b1;
      if (clear_accumulator || dump || !started) begin
        len_l  <= len_in;
        mode_l <= mode;
      end
      if (clear_accumulator) sym_count <= sym_clk_ena ? CNT_W'(1) : '0;
      else if (dump)         sym_count <= '0;
      else if (sym_clk_ena)  sym_count <= sym_count + CNT_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    error_acc_channel #(
      .DATA_WIDTH     (DATA_WIDTH),
      .ACC_DATA_WIDTH (ACC_DATA_WIDTH),
      .LEN_W          (LEN_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear_accumulator),
      .ena      (sym_clk_ena),
      .dump     (dump),
      .mode_l   (mode_eff),
      .len_l    (len_eff),
      .error    (error[c*DATA_WIDTH +: DATA_WIDTH]),
      .acc_out  (acc_error_out[c*ACC_DATA_WIDTH +: ACC_DATA_WIDTH]),
      .mean_out (mean_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .ovf_out  (ovf_out[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_error_accumulator.sv
// tb/tb_multi_channel_error_accumulator.sv - directed self-checking bench
module tb_multi_channel_error_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sym_clk_ena = 1'b0;
  logic        clear_accumulator = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  log2_len = 5'd2;
  logic [35:0] error = '0;

  logic [71:0] acc_error_out;
  logic [35:0] mean_out;
  logic [1:0]  ovf_out;
  logic        out_valid;
  logic [16:0] sym_count;

  logic [39:0] s_acc_error_out;
  logic [35:0] s_mean_out;
  logic [1:0]  s_ovf_out;
  logic        s_out_valid;
  logic [16:0] s_sym_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multi_channel_error_accumulator dut (
    .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena),
    .clear_accumulator(clear_accumulator), .mode(mode), .log2_len(log2_len),
    .error(error), .acc_error_out(acc_error_out), .mean_out(mean_out),
    .ovf_out(ovf_out), .out_valid(out_valid), .sym_count(sym_count)
  );

  multi_channel_error_accumulator #(.ACC_DATA_WIDTH(20)) dut_s (
    .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena),
    .clear_accumulator(clear_accumulator), .mode(mode), .log2_len(log2_len),
    .error(error), .acc_error_out(s_acc_error_out), .mean_out(s_mean_out),
    .ovf_out(s_ovf_out), .out_valid(s_out_valid), .sym_count(s_sym_count)
  );

  task automatic step(input logic en, input logic clr, input int e0, input int e1);
    @(negedge clk);
    sym_clk_ena = en;
    clear_accumulator = clr;
    error = {18'(e1), 18'(e0)};
    @(posedge clk);
    #1;
    sym_clk_ena = 1'b0;
    clear_accumulator = 1'b0;
  endtask

  task automatic start_window(input logic m, input logic [4:0] l);
    mode = m;
    log2_len = l;
    step(1'b0, 1'b1, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({acc_error_out, mean_out, ovf_out, out_valid, sym_count} !== '0)
      $display("FAIL reset_outputs got acc=%h mean=%h ovf=%b v=%b cnt=%0d want all 0",
               acc_error_out, mean_out, ovf_out, out_valid, sym_count);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_dc_sum();
    step(1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b0, -3, 0);
    step(1'b1, 1'b0, 5, 0);
    total_cnt++;
    if (out_valid !== 1'b0 || sym_count !== 17'd3)
      $display("FAIL dc_pre_dump got v=%b cnt=%0d want v=0 cnt=3", out_valid, sym_count);
    else pass_cnt++;
    step(1'b1, 1'b0, 4, 0);
    total_cnt++;
    if (out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== 36'sd16 || $signed(mean_out[17:0]) !== 18'sd4
        || ovf_out !== 2'b00 || sym_count !== 17'd0)
      $display("FAIL dc_dump got v=%b acc=%0d mean=%0d ovf=%b cnt=%0d want 1 16 4 00 0", out_valid,
               $signed(acc_error_out[35:0]), $signed(mean_out[17:0]), ovf_out, sym_count);
    else pass_cnt++;
    step(1'b0, 1'b0, 0, 0);
    total_cnt++;
    if (out_valid !== 1'b0 || $signed(acc_error_out[35:0]) !== 36'sd16)
      $display("FAIL dc_hold got v=%b acc=%0d want v=0 acc=16", out_valid, $signed(acc_error_out[35:0]));
    else pass_cnt++;
  endtask

  task automatic test_abs();
    start_window(1'b1, 5'd1);
    step(1'b1, 1'b0, 0, -131072);
    step(1'b1, 1'b0, 0, -6);
    total_cnt++;
    if (out_valid !== 1'b1 || acc_error_out[71:36] !== 36'd131078 || mean_out[35:18] !== 18'd65539
        || ovf_out[1] !== 1'b0 || acc_error_out[35:0] !== 36'd0)
      $display("FAIL abs_dump got v=%b acc1=%0d mean1=%0d ovf1=%b acc0=%0d want 1 131078 65539 0 0",
               out_valid, acc_error_out[71:36], mean_out[35:18], ovf_out[1], acc_error_out[35:0]);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    start_window(1'b0, 5'd3);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 131071, 0);
    total_cnt++;
    if (s_out_valid !== 1'b1 || s_acc_error_out[19:0] !== 20'd524287 || s_ovf_out !== 2'b01
        || s_mean_out[17:0] !== 18'd65535)
      $display("FAIL sat_narrow got v=%b acc=%0d ovf=%b mean=%0d want 1 524287 01 65535",
               s_out_valid, s_acc_error_out[19:0], s_ovf_out, s_mean_out[17:0]);
    else pass_cnt++;
    total_cnt++;
    if (acc_error_out[35:0] !== 36'd1048568 || ovf_out !== 2'b00 || mean_out[17:0] !== 18'd131071)
      $display("FAIL sat_wide got acc=%0d ovf=%b mean=%0d want 1048568 00 131071",
               acc_error_out[35:0], ovf_out, mean_out[17:0]);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1, 0);
    total_cnt++;
    if (s_out_valid !== 1'b1 || s_acc_error_out[19:0] !== 20'd8 || s_ovf_out !== 2'b00 || s_mean_out[17:0] !== 18'd1)
      $display("FAIL sat_clean got v=%b acc=%0d ovf=%b mean=%0d want 1 8 00 1",
               s_out_valid, s_acc_error_out[19:0], s_ovf_out, s_mean_out[17:0]);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    start_window(1'b0, 5'd2);
    step(1'b1, 1'b0, 100, 0);
    step(1'b1, 1'b0, 100, 0);
    step(1'b1, 1'b1, 7, 0);
    total_cnt++;
    if (out_valid !== 1'b0 || sym_count !== 17'd1)
      $display("FAIL clear_load got v=%b cnt=%0d want v=0 cnt=1", out_valid, sym_count);
    else pass_cnt++;
    step(1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b0, 1, 0);
    total_cnt++;
    if (out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== 36'sd10 || $signed(mean_out[17:0]) !== 18'sd2)
      $display("FAIL clear_dump got v=%b acc=%0d mean=%0d want 1 10 2", out_valid,
               $signed(acc_error_out[35:0]), $signed(mean_out[17:0]));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int vcount;
    start_window(1'b0, 5'd2);
    vcount = 0;
    step(1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b0, 1, 0);
    log2_len = 5'd0;
    step(1'b1, 1'b0, 1, 0);
    vcount += int'(out_valid);
    step(1'b1, 1'b0, 1, 0);
    total_cnt++;
    if (vcount !== 0 || out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== 36'sd4)
      $display("FAIL len_change_old got early=%0d v=%b acc=%0d want 0 1 4", vcount, out_valid,
               $signed(acc_error_out[35:0]));
    else pass_cnt++;
    step(1'b1, 1'b0, -5, 0);
    total_cnt++;
    if (out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== -36'sd5 || $signed(mean_out[17:0]) !== -18'sd5)
      $display("FAIL len_zero_a got v=%b acc=%0d mean=%0d want 1 -5 -5", out_valid,
               $signed(acc_error_out[35:0]), $signed(mean_out[17:0]));
    else pass_cnt++;
    log2_len = 5'd1;
    step(1'b1, 1'b0, 3, 0);
    total_cnt++;
    if (out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== 36'sd3)
      $display("FAIL len_zero_b got v=%b acc=%0d want 1 3", out_valid, $signed(acc_error_out[35:0]));
    else pass_cnt++;
    step(1'b1, 1'b0, -3, 0);
    step(1'b1, 1'b0, 0, 0);
    total_cnt++;
    if (out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== -36'sd3 || $signed(mean_out[17:0]) !== -18'sd2)
      $display("FAIL floor_mean got v=%b acc=%0d mean=%0d want 1 -3 -2", out_valid,
               $signed(acc_error_out[35:0]), $signed(mean_out[17:0]));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int vcount;
    start_window(1'b0, 5'd2);
    step(1'b1, 1'b0, 5, 5);
    step(1'b1, 1'b0, 5, 5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({acc_error_out, mean_out, ovf_out, out_valid, sym_count} !== '0)
      $display("FAIL async_reset got acc=%h mean=%h ovf=%b v=%b cnt=%0d want all 0",
               acc_error_out, mean_out, ovf_out, out_valid, sym_count);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    vcount = 0;
    step(1'b1, 1'b0, 1, 0);
    vcount += int'(out_valid);
    step(1'b1, 1'b0, 2, 0);
    vcount += int'(out_valid);
    step(1'b1, 1'b0, 3, 0);
    vcount += int'(out_valid);
    step(1'b1, 1'b0, 4, 0);
    total_cnt++;
    if (vcount !== 0 || out_valid !== 1'b1 || $signed(acc_error_out[35:0]) !== 36'sd10
        || acc_error_out[71:36] !== 36'd0)
      $display("FAIL post_reset_dump got early=%0d v=%b acc0=%0d acc1=%0d want 0 1 10 0", vcount,
               out_valid, $signed(acc_error_out[35:0]), acc_error_out[71:36]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_dc_sum();
    test_abs();
    test_saturation();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multi_channel_error_accumulator.md
Name: multi_channel_error_accumulator

Overview:
- Parametrised successor to the single-channel DC-error accumulator: NUM_CH independent channels (e.g. I/Q) accumulate a per-symbol error over a programmable window of 2^log2_len symbols.
- At window end it auto-dumps the raw sum and the window mean (sum >>> log2_len), then restarts.
- Two accumulation modes (signed sum for DC offset, magnitude sum for mean-abs-error/MER) and saturating arithmetic with a per-window overflow flag.
- Sits after the slicer/error block in the receiver; feeds the DC-correction loop and MER reporting.

Parameters:
- NUM_CH, 2, number of independent channels
- DATA_WIDTH, 18, signed error sample width per channel
- ACC_DATA_WIDTH, 36, signed accumulator width per channel (must be >= DATA_WIDTH+2)
- MAX_LOG2_LEN, 16, largest allowed log2 window length
- LEN_W, 5, width of log2_len port (must hold MAX_LOG2_LEN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sym_clk_ena  in  1  one-clk strobe; accept one error sample per channel
- clear_accumulator  in  1  abort current window, restart (no dump)
- mode  in  1  0 = signed sum, 1 = sum of |error|
- log2_len  in  LEN_W  window length exponent, latched at window start
- error  in  NUM_CH*DATA_WIDTH  packed signed errors, ch0 in LSBs
- acc_error_out  out  NUM_CH*ACC_DATA_WIDTH  dumped raw sums
- mean_out  out  NUM_CH*DATA_WIDTH  dumped means, saturated to DATA_WIDTH
- ovf_out  out  NUM_CH  per-channel saturation occurred in dumped window
- out_valid  out  1  one-clk pulse when outputs update
- sym_count  out  MAX_LOG2_LEN+1  symbols accepted in current window

Behaviour:
- Reset (async, reset_n=0): all accumulators, sym_count, acc_error_out, mean_out, ovf_out, out_valid = 0; latched length = 0 (window of 1); latched mode = 0.
- Window start (reset release, clear, or dump): latch len_l = min(log2_len, MAX_LOG2_LEN) and mode_l = mode. Changes to either mid-window have no effect until next window start.
- Sample term per channel: mode_l=0 -> sign-extended error; mode_l=1 -> |error| computed at DATA_WIDTH+1 bits (so -2^(DW-1) gives +2^(DW-1)), zero-extended.
- Accumulate: on sym_clk_ena, acc <= sat(acc + term), sym_count += 1. Saturation clamps to +/-(2^(ACC-1)) limits (max = 2^(ACC-1)-1, min = -2^(ACC-1)); any clamp sets that channel's sticky ovf bit for the window.
- Dump: on sym_clk_ena when sym_count == 2^len_l - 1, same edge: acc_error_out <= sat(acc + term); mean_out <= sat_DW(that sum >>> len_l) (arithmetic, floor); ovf_out <= sticky ovf OR ovf of this add; out_valid <= 1; acc <= 0; sym_count <= 0; sticky ovf cleared; new len_l/mode_l latched.
- out_valid is high exactly one clk after the dump edge, otherwise 0. Outputs hold between dumps.
- clear_accumulator has priority over sym_clk_ena/dump. clear without ena: acc <= 0, count <= 0, no dump. clear with ena: acc <= term of current sample, count <= 1, ovf cleared (matches legacy load-on-clear semantics). Latch len/mode in both cases; outputs untouched, out_valid = 0.
- len_l = 0: every sym_clk_ena dumps; mean = sample.
- Back-to-back sym_clk_ena every clk fully supported; no stall or back-pressure.
- Reset asserted mid-window: partial window discarded, no out_valid.
- Latency: dump data visible the clk edge after the final sample is presented with sym_clk_ena.

Decomposition:
- Shared package: mode encodings (MODE_DC=0, MODE_ABS=1), saturation min/max constant functions for ACC_DATA_WIDTH and DATA_WIDTH.
- One sub-module, error_acc_channel: one channel's term select, saturating add, sticky ovf, mean shift/saturate. Generated NUM_CH times. Top holds the shared counter, len/mode latches and out_valid.

Test Plan:
- log2_len=2, mode=0, ch0 errors 10,-3,5,4 on 4 strobes -> out_valid once; acc_error_out ch0=16, mean_out ch0=4, ovf=0; sym_count back to 0.
- mode=1, log2_len=1, ch1 errors -131072,-6 -> ch1 sum=131078, mean=65539, ovf_out ch1=0.
- ACC_DATA_WIDTH=20, DATA_WIDTH=18, log2_len=3, eight samples of +131071 -> acc_error_out=524287 (clamped), ovf_out=1, mean=65535; next clean window -> ovf_out=0.
- Two strobes into window of 4, then clear_accumulator with sym_clk_ena and error=7 -> no out_valid; after 3 more strobes of 1, sum = 10.
- log2_len changed 2->0 mid-window -> current window still dumps after 4 samples; next window dumps on every strobe.
- reset_n low for 1 clk mid-window (async, between edges) -> all outputs 0 immediately; first dump after release covers only post-reset samples.
